// File: rtl/shift_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_seq_ctrl_if : job handshake and shift-register control bundle   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface shift_seq_ctrl_if #(
  parameter int size  = 4,
  parameter int cnt_w = 3
) ();
  logic             start_valid;
  logic             start_ready;
  logic [size-1:0]  start_data;
  logic [cnt_w-1:0] start_count;
  logic             stall;
  logic             abort;
  logic             load;
  logic             ena;
  logic [size-1:0]  data;
  logic             busy;
  logic [cnt_w-1:0] remain;
  logic             done;
  logic             aborted;

  modport slave (
    input  start_valid, start_data, start_count, stall, abort,
    output start_ready, load, ena, data, busy, remain, done, aborted
  );

  modport master (
    output start_valid, start_data, start_count, stall, abort,
    input  start_ready, load, ena, data, busy, remain, done, aborted
  );
endinterface
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_seq_ctrl : load-then-shift job sequencer with stall and abort   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module shift_seq_ctrl #(
  parameter int size  = 4,
  parameter int cnt_w = 3
) (
  input  wire logic       clk,
  input  wire logic       reset,
  shift_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [size-1:0]  r_data;
  logic [cnt_w-1:0] r_remain;
  logic             r_aborted;
  logic             w_accept;
  logic             w_abort;
  logic             w_load;
  logic             w_ena;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_abort  = 1'b0;
    w_load   = 1'b0;
    w_ena    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_valid) begin
          w_accept = 1'b1;
          w_next   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.abort) begin
          w_abort = 1'b1;
          w_next  = ST_DONE;
        end else begin
          w_load = 1'b1;
          w_next = (r_remain != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        // abort takes priority over stall
        if (bus.abort) begin
          w_abort = 1'b1;
          w_next  = ST_DONE;
        end else if (!bus.stall) begin
          w_ena = 1'b1;
          if (r_remain == cnt_w'(1)) begin
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Abort clears the owed count so DONE always presents remain=0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= '0;
      r_remain  <= '0;
      r_aborted <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data   <= bus.start_data;
        r_remain <= bus.start_count;
      end else if (w_abort) begin
        r_remain <= '0;
      end else if (w_ena) begin
        r_remain <= r_remain - cnt_w'(1);
      end

      if (w_abort) begin
        r_aborted <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_aborted <= 1'b0;
      end
    end
  end

  assign bus.start_ready = (r_state == ST_IDLE);
  assign bus.load        = w_load;
  assign bus.ena         = w_ena;
  assign bus.data        = r_data;
  assign bus.busy        = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
  assign bus.remain      = r_remain;
  assign bus.done        = (r_state == ST_DONE);
  assign bus.aborted     = (r_state == ST_DONE) && r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_seq_ctrl : scoreboard bench, directed and random jobs        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_shift_seq_ctrl;
  localparam int SZ = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic          rdy;
    logic          ld;
    logic          en;
    logic          bsy;
    logic          dn;
    logic          ab;
    logic [CW-1:0] rem;
    logic [SZ-1:0] dat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  exp_t          q[$];
  exp_t          e_pop;
  exp_t          act;
  int            pass_cnt = 0;
  int            total_cnt = 0;
  bit            mon_en = 1'b0;
  logic [SZ-1:0] last_data;

  shift_seq_ctrl_if #(.size(SZ), .cnt_w(CW)) bus ();

  shift_seq_ctrl #(.size(SZ), .cnt_w(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(bit rdy, bit ld, bit en, bit bs, bit dn, bit ab,
                              int rem, logic [SZ-1:0] dat);
    exp_t r;
    r.rdy = rdy; r.ld = ld; r.en = en; r.bsy = bs; r.dn = dn; r.ab = ab;
    r.rem = CW'(rem);
    r.dat = dat;
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      act = {bus.start_ready, bus.load, bus.ena, bus.busy, bus.done, bus.aborted,
             bus.remain, bus.data};
      total_cnt++;
      if (q.size() == 0) begin
        $display("FAIL underflow @%0t: no expected entry for actual %b", $time, act);
      end else begin
        e_pop = q.pop_front();
        if (act === e_pop) pass_cnt++;
        else $display("FAIL outputs @%0t: actual rdy=%b ld=%b en=%b busy=%b done=%b ab=%b rem=%0d data=%h, required rdy=%b ld=%b en=%b busy=%b done=%b ab=%b rem=%0d data=%h",
                      $time, act.rdy, act.ld, act.en, act.bsy, act.dn, act.ab, act.rem, act.dat,
                      e_pop.rdy, e_pop.ld, e_pop.en, e_pop.bsy, e_pop.dn, e_pop.ab, e_pop.rem, e_pop.dat);
      end
      total_cnt++;
      if (!(bus.load === 1'b1 && bus.ena === 1'b1)) pass_cnt++;
      else $display("FAIL load_ena_exclusive @%0t: actual load=1 ena=1, required not both", $time);
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    reset           = 1'b0;
    bus.start_valid = 1'b0;
    bus.start_data  = SZ'($urandom);
    bus.start_count = CW'($urandom);
    bus.stall       = 1'($urandom);
    bus.abort       = 1'($urandom);
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, last_data));
  endtask

  // mode: 0 random, 1 clean, 2 stall on 2nd shift, 3 abort on 1st shift, 4 reset on 3rd shift
  task automatic run_job(input logic [SZ-1:0] d, input int n, input int mode);
    bit   st[64];
    bit   ab[64];
    bit   rs[64];
    exp_t recs[$];
    int   rem;
    int   k;
    bit   abrt;
    bit   rhit;

    @(posedge clk); #1;
    reset           = 1'b0;
    bus.start_valid = 1'b1;
    bus.start_data  = d;
    bus.start_count = CW'(n);
    bus.stall       = 1'($urandom);
    bus.abort       = 1'($urandom);
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, last_data));

    for (int i = 0; i < 64; i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; rs[i] = 1'b0;
      if (mode == 0) begin
        st[i] = (i < 40) && ($urandom_range(0, 99) < 30);
        ab[i] = ($urandom_range(0, 99) < 6);
        rs[i] = ($urandom_range(0, 99) < 2);
      end
    end
    if (mode == 2) st[3] = 1'b1;
    if (mode == 3) ab[2] = 1'b1;
    if (mode == 4) rs[4] = 1'b1;

    // Expected timeline: one LOAD cycle, then one cycle per owed shift or stall, then DONE
    rem  = n;
    abrt = ab[1];
    rhit = rs[1];
    recs.push_back(mk(0, !ab[1], 0, 1, 0, 0, rem, d));
    k = 2;
    while (rem > 0 && !abrt && !rhit) begin
      if (ab[k]) begin
        recs.push_back(mk(0, 0, 0, 1, 0, 0, rem, d));
        abrt = 1'b1;
      end else if (st[k]) begin
        recs.push_back(mk(0, 0, 0, 1, 0, 0, rem, d));
      end else begin
        recs.push_back(mk(0, 0, 1, 1, 0, 0, rem, d));
        rem--;
      end
      rhit = rs[k];
      k++;
    end
    if (!rhit) begin
      recs.push_back(mk(0, 0, 0, 0, 1, abrt, 0, d));
      rs[recs.size()] = 1'b0;
    end
    foreach (recs[i]) q.push_back(recs[i]);

    for (int i = 1; i <= recs.size(); i++) begin
      @(posedge clk); #1;
      reset           = rs[i];
      bus.stall       = st[i];
      bus.abort       = ab[i];
      bus.start_valid = (mode == 4 && rs[i]) ? 1'b1 : 1'($urandom);
      bus.start_data  = SZ'($urandom);
      bus.start_count = CW'($urandom);
    end
    last_data = rhit ? '0 : d;
  endtask

  initial begin
    reset           = 1'b1;
    bus.start_valid = 1'b1;
    bus.start_data  = 4'hA;
    bus.start_count = 3'd3;
    bus.stall       = 1'b0;
    bus.abort       = 1'b0;
    last_data       = '0;

    // Reset held two cycles with start_valid high must stay idle
    @(posedge clk); #1;
    mon_en = 1'b1;
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, '0));
    @(posedge clk); #1;
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, '0));
    idle_cycle();

    run_job(4'b1111, 2, 1);
    idle_cycle();
    run_job(4'b0110, 0, 1);
    run_job(4'b1001, 3, 2);
    run_job(4'b0101, 3, 3);
    run_job(4'b0011, 5, 4);
    idle_cycle();
    run_job(4'b1100, 7, 1);

    for (int j = 0; j < 150; j++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      run_job(SZ'($urandom), $urandom_range(0, 7), 0);
    end
    idle_cycle();
    idle_cycle();

    @(posedge clk);
    mon_en = 1'b0;
    total_cnt++;
    if (q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: actual %0d entries left, required 0", q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter size, default 4, giving the shift-register data width.
REQ-002 The block SHALL have parameter cnt_w, default 3, giving the shift-count width (max count 2^cnt_w-1).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port start_valid  input  1  request to run one load-then-shift job.
REQ-006 The block SHALL have port start_ready  output  1  controller idle, job acceptable this cycle.
REQ-007 The block SHALL have port start_data  input  size  word to load into the shift register.
REQ-008 The block SHALL have port start_count  input  cnt_w  number of shift (ena) cycles for the job.
REQ-009 The block SHALL have port stall  input  1  pause shifting without losing progress.
REQ-010 The block SHALL have port abort  input  1  terminate the current job early.
REQ-011 The block SHALL have port load  output  1  load strobe to the shift register.
REQ-012 The block SHALL have port ena  output  1  shift enable to the shift register.
REQ-013 The block SHALL have port data  output  size  load value to the shift register.
REQ-014 The block SHALL have port busy  output  1  job in progress (LOAD or SHIFT).
REQ-015 The block SHALL have port remain  output  cnt_w  shift cycles still owed.
REQ-016 The block SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-017 The block SHALL have port aborted  output  1  qualifies done, 1 when the job ended by abort.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-019 start_ready SHALL be 1 exactly when state is IDLE; start_valid in any other state is ignored.
REQ-020 On start_valid&start_ready the block SHALL latch start_data into data and start_count into remain, then enter LOAD.
REQ-021 In LOAD, load SHALL be 1 and ena 0 for exactly one cycle; next state is SHIFT if remain>0, else DONE.
REQ-022 In SHIFT, ena SHALL equal !stall&!abort; load SHALL be 0.
REQ-023 Each cycle with ena=1, remain SHALL decrement by 1; when ena=1 and remain=1, next state is DONE.
REQ-024 stall=1 in SHIFT SHALL hold state and remain unchanged; stall in IDLE, LOAD, DONE has no effect.
REQ-025 abort=1 in LOAD or SHIFT SHALL force load=0 and ena=0 that cycle, next state DONE with aborted=1; abort wins over stall.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 In DONE, done SHALL be 1 for exactly one cycle, remain SHALL be 0, next state IDLE.
REQ-028 aborted SHALL be 0 in DONE after a normal completion and 0 in all non-DONE states.
REQ-029 busy SHALL be 1 in LOAD and SHIFT only.
REQ-030 load and ena SHALL never be 1 in the same cycle.
REQ-031 data SHALL hold the latched value until the next accepted job.
REQ-032 Total job latency from accept edge to done SHALL be 2+N+S cycles (N = count, S = stall cycles); N=0 gives done 2 cycles after accept.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE, remain=0, data=0, aborted=0, overriding all other inputs including start_valid.
REQ-034 After reset: load=0, ena=0, busy=0, done=0, start_ready=1.
REQ-035 reset during LOAD or SHIFT SHALL drop the job with no done pulse.

Verification
REQ-036 Reset: reset=1 for 2 cycles -> load=0, ena=0, busy=0, done=0, remain=0, start_ready=1.
REQ-037 Normal: accept at T0 with data=4'b1111, count=2 -> T1 load=1 data=1111; T2,T3 ena=1 (remain 2->1->0); T4 done=1 aborted=0; T5 start_ready=1.
REQ-038 Zero count: accept count=0 -> T1 load=1; T2 done=1; ena never 1.
REQ-039 Stall: count=3, stall=1 on second SHIFT cycle -> ena pattern 1,0,1,1, remain holds at 2 during stall, done at T6.
REQ-040 Abort: count=3, abort=1 on first SHIFT cycle -> ena=0 that cycle, next cycle done=1 aborted=1, remain=0.
REQ-041 Reset mid-job: count=5, reset=1 on third SHIFT cycle -> next cycle IDLE, ena=0, remain=0, no done pulse; start_valid held high during reset is not accepted.
